// File: rtl/fetch_bundle_producer.sv
// Fetches aligned instruction blocks and hands each one to the instruction FIFO as a tagged bundle.
// Optional build macro STOP_AT_BRANCH_EN truncates a bundle at its first control-flow slot.
module fetch_bundle_producer #(
  parameter int NUM_FIFO_INPUT_ENTRY = 4,
  parameter int BW_PC_MOD = $clog2(NUM_FIFO_INPUT_ENTRY),
  parameter int BW_PC = 32,
  parameter logic [BW_PC-1:0] BOOT_PC = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              o_mem_valid,
  input  logic                              i_mem_ready,
  output logic [BW_PC-1:0]                  o_mem_addr,
  input  logic                              i_mem_rsp_valid,
  input  logic [32*NUM_FIFO_INPUT_ENTRY-1:0] i_mem_rsp_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [32*NUM_FIFO_INPUT_ENTRY-1:0] o_bundle,
  output logic [BW_PC-1:0]                  o_pc,
  output logic [BW_PC_MOD-1:0]              o_pc_mod_select,
  output logic [BW_PC_MOD-1:0]              o_pc_upperbound,
  input  logic                              i_flush,
  input  logic [BW_PC-1:0]                  i_flush_pc
);

  localparam int BW_BUNDLE = 32 * NUM_FIFO_INPUT_ENTRY;
  localparam logic [BW_PC_MOD-1:0] LAST_SLOT = BW_PC_MOD'(NUM_FIFO_INPUT_ENTRY - 1);

  typedef enum logic [1:0] {REQ, WAIT, SEND, DRAIN} state_t;

  state_t                 state_reg;
  logic [BW_PC-1:0]       pc_reg;
  logic [BW_BUNDLE-1:0]   bundle_reg;
  logic [BW_PC_MOD-1:0]   upperbound_reg;

  logic [BW_PC_MOD-1:0]   mod_select;
  logic [BW_PC_MOD-1:0]   upperbound_next;
  logic [BW_PC-1:0]       block_base;
  logic [BW_PC_MOD:0]     slot_count;
  logic [BW_PC-1:0]       pc_fallthrough;

  assign mod_select     = pc_reg[BW_PC_MOD+1:2];
  assign block_base     = {pc_reg[BW_PC-1:BW_PC_MOD+2], {(BW_PC_MOD+2){1'b0}}};
  assign slot_count     = {1'b0, upperbound_reg} + (BW_PC_MOD+1)'(1);
  assign pc_fallthrough = block_base + BW_PC'({slot_count, 2'b00});

`ifdef STOP_AT_BRANCH_EN
  logic [NUM_FIFO_INPUT_ENTRY-1:0] slot_is_cf;

  // Only slots at or after the entry slot can terminate the bundle.
  generate
    for (genvar gi = 0; gi < NUM_FIFO_INPUT_ENTRY; gi++) begin : g_predecode
      logic [6:0] opcode;
      assign opcode = i_mem_rsp_data[32*gi +: 7];
      assign slot_is_cf[gi] = (BW_PC_MOD'(gi) >= mod_select) &&
                              ((opcode == 7'b1100011) || (opcode == 7'b1101111) ||
                               (opcode == 7'b1100111));
    end
  endgenerate

  always_comb begin
    upperbound_next = LAST_SLOT;
    for (int k = NUM_FIFO_INPUT_ENTRY - 1; k >= 0; k--) begin
      if (slot_is_cf[k]) upperbound_next = BW_PC_MOD'(k);
    end
  end
`else
  assign upperbound_next = LAST_SLOT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= REQ;
      pc_reg         <= BOOT_PC;
      bundle_reg     <= '0;
      upperbound_reg <= LAST_SLOT;
    end else begin
      case (state_reg)
        REQ: begin
          if (i_mem_ready) state_reg <= i_flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (i_mem_rsp_valid) begin
            if (i_flush) begin
              state_reg <= REQ;
            end else begin
              bundle_reg     <= i_mem_rsp_data;
              upperbound_reg <= upperbound_next;
              state_reg      <= SEND;
            end
          end else if (i_flush) begin
            state_reg <= DRAIN;
          end
        end
        SEND: begin
          if (i_flush) begin
            state_reg <= REQ;
          end else if (i_ready) begin
            pc_reg    <= pc_fallthrough;
            state_reg <= REQ;
          end
        end
        DRAIN: begin
          // The stale response is swallowed; a flush here only retargets pc.
          if (i_mem_rsp_valid) state_reg <= REQ;
        end
        default: state_reg <= REQ;
      endcase
      if (i_flush) pc_reg <= i_flush_pc;
    end
  end

  assign o_mem_valid     = (state_reg == REQ);
  assign o_valid         = (state_reg == SEND);
  assign o_mem_addr      = block_base;
  assign o_bundle        = bundle_reg;
  assign o_pc            = pc_reg;
  assign o_pc_mod_select = mod_select;
  assign o_pc_upperbound = upperbound_reg;

endmodule

// File: tb/tb_fetch_bundle_producer.sv
// Randomized bench for fetch_bundle_producer: a transaction-level fetch model and a
// one-outstanding memory model predict every output on every cycle.
module tb_fetch_bundle_producer;

  localparam int N = 4;
  localparam int BW_CHK = 32 * N;
  localparam logic [31:0] BOOT = 32'h100;
  localparam logic [31:0] ALIGN_MASK = ~32'(4 * N - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef STOP_AT_BRANCH_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              o_mem_valid;
  logic              i_mem_ready;
  logic [31:0]       o_mem_addr;
  logic              i_mem_rsp_valid;
  logic [BW_CHK-1:0] i_mem_rsp_data;
  logic              o_valid;
  logic              i_ready;
  logic [BW_CHK-1:0] o_bundle;
  logic [31:0]       o_pc;
  logic [1:0]        o_pc_mod_select;
  logic [1:0]        o_pc_upperbound;
  logic              i_flush;
  logic [31:0]       i_flush_pc;

  fetch_bundle_producer #(
    .NUM_FIFO_INPUT_ENTRY(N),
    .BW_PC(32),
    .BOOT_PC(BOOT)
  ) dut (
    .clk(clk), .rst(rst),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_bundle(o_bundle), .o_pc(o_pc),
    .o_pc_mod_select(o_pc_mod_select), .o_pc_upperbound(o_pc_upperbound),
    .i_flush(i_flush), .i_flush_pc(i_flush_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: pc of the next bundle, the single in-flight fetch, the held bundle.
  logic [31:0]       exp_pc;
  bit                outstanding, out_stale, have_bundle;
  logic [BW_CHK-1:0] bun_data;
  logic [1:0]        bun_ub;

  // Memory model.
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_override [logic [31:0]];

  task automatic check(input string tag, input logic [BW_CHK-1:0] got, input logic [BW_CHK-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (mem_override.exists(a)) return mem_override[a];
    h = (a * 32'h9E37_79B1) ^ (a >> 5) ^ 32'h5BD1_E995;
    case (h[9:7])
      3'd0:    op = 7'b1100011;
      3'd1:    op = 7'b1101111;
      3'd2:    op = 7'b1100111;
      default: op = 7'b0010011;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic logic [BW_CHK-1:0] block_data(input logic [31:0] base);
    logic [BW_CHK-1:0] d;
    for (int k = 0; k < N; k++) d[32*k +: 32] = mem_word(base + 32'(4 * k));
    return d;
  endfunction

  // Last slot of a bundle entered at slot sel.
  function automatic logic [1:0] exp_ub(input logic [BW_CHK-1:0] d, input logic [1:0] sel);
    logic [1:0] ub;
    logic [6:0] op;
    ub = 2'(N - 1);
    for (int k = N - 1; k >= int'(sel); k--) begin
      op = d[32*k +: 7];
      if (STOP_EN && (op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111)) ub = 2'(k);
    end
    return ub;
  endfunction

  task automatic check_outputs();
    bit exp_mv;
    exp_mv = !outstanding && !have_bundle;
    check("mem_valid", BW_CHK'(o_mem_valid), BW_CHK'(exp_mv));
    check("valid", BW_CHK'(o_valid), BW_CHK'(have_bundle));
    check("pc", BW_CHK'(o_pc), BW_CHK'(exp_pc));
    if (exp_mv) check("mem_addr", BW_CHK'(o_mem_addr), BW_CHK'(exp_pc & ALIGN_MASK));
    if (have_bundle) begin
      check("select", BW_CHK'(o_pc_mod_select), BW_CHK'(exp_pc[3:2]));
      check("upperbound", BW_CHK'(o_pc_upperbound), BW_CHK'(bun_ub));
      check("bundle", o_bundle, bun_data);
    end
  endtask

  // One clock: check outputs, drive inputs, advance memory and model across the edge.
  task automatic cycle(input bit mr, input bit rdy, input bit fl, input logic [31:0] fpc, input int lat);
    bit          req_acc, rsp, xfer;
    logic [31:0] req_addr;
    check_outputs();
    i_mem_ready     = mr && !mem_busy;
    i_mem_rsp_valid = mem_busy && (mem_wait == 0);
    if (i_mem_rsp_valid) begin
      i_mem_rsp_data = block_data(mem_addr_q);
    end else begin
      for (int k = 0; k < N; k++) i_mem_rsp_data[32*k +: 32] = $urandom;
    end
    i_flush    = fl;
    i_flush_pc = fpc;
    i_ready    = rdy && !fl;
    req_acc  = o_mem_valid && i_mem_ready;
    req_addr = o_mem_addr;
    rsp      = i_mem_rsp_valid;
    xfer     = o_valid && i_ready;
    @(posedge clk);
    if (rsp) mem_busy = 1'b0;
    else if (mem_busy && mem_wait > 0) mem_wait--;
    if (req_acc) begin
      mem_busy   = 1'b1;
      mem_wait   = lat;
      mem_addr_q = req_addr;
    end
    if (xfer) begin
      $display("[TB] bundle pc=0x%08h sel=%0d ub=%0d", exp_pc, exp_pc[3:2], bun_ub);
      exp_pc      = (exp_pc & ALIGN_MASK) + 32'(4 * (int'(bun_ub) + 1));
      have_bundle = 1'b0;
    end
    if (rsp) begin
      if (outstanding && !out_stale && !fl) begin
        have_bundle = 1'b1;
        bun_data    = block_data(exp_pc & ALIGN_MASK);
        bun_ub      = exp_ub(bun_data, exp_pc[3:2]);
      end
      outstanding = 1'b0;
    end
    if (req_acc) begin
      outstanding = 1'b1;
      out_stale   = 1'b0;
    end
    if (fl) begin
      exp_pc      = fpc;
      have_bundle = 1'b0;
      if (outstanding) out_stale = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_mem_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
    i_flush = 1'b0; i_flush_pc = '0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = BOOT; outstanding = 1'b0; out_stale = 1'b0; have_bundle = 1'b0;
    bun_data = '0; bun_ub = 2'(N - 1);
    mem_busy = 1'b0; mem_wait = 0; mem_addr_q = '0;
  endtask

  task automatic run_until_valid(input bit mr, input int lat, input int max_cycles);
    int n = 0;
    while (!o_valid && n < max_cycles) begin
      cycle(mr, 1'b0, 1'b0, 32'h0, lat);
      n++;
    end
    check("reach_valid", BW_CHK'(o_valid), BW_CHK'(1'b1));
  endtask

  task automatic run_until_mem_valid(input int max_cycles);
    int n = 0;
    while (!o_mem_valid && n < max_cycles) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 0);
      n++;
    end
    check("reach_mem_valid", BW_CHK'(o_mem_valid), BW_CHK'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fpc;
    for (int a = 32'h100; a < 32'h220; a += 4) mem_override[32'(a)] = NOP;
    for (int a = 32'h300; a < 32'h320; a += 4) mem_override[32'(a)] = NOP;
    for (int a = 32'h400; a < 32'h420; a += 4) mem_override[32'(a)] = NOP;
    mem_override[32'h404] = 32'h0000_0063;

    do_reset();
    check("boot_mem_valid", BW_CHK'(o_mem_valid), BW_CHK'(1'b1));
    check("boot_valid", BW_CHK'(o_valid), BW_CHK'(1'b0));
    check("boot_mem_addr", BW_CHK'(o_mem_addr), BW_CHK'(32'h100));
    check("boot_pc", BW_CHK'(o_pc), BW_CHK'(32'h100));

    // Straight-line fetch from reset.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);
    run_until_valid(1'b1, 0, 10);
    check("t1_pc", BW_CHK'(o_pc), BW_CHK'(32'h100));
    check("t1_sel", BW_CHK'(o_pc_mod_select), BW_CHK'(2'd0));
    check("t1_ub", BW_CHK'(o_pc_upperbound), BW_CHK'(2'd3));
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check("t1_next_addr", BW_CHK'(o_mem_addr), BW_CHK'(32'h110));

    // Flush while presenting a bundle.
    run_until_valid(1'b1, 0, 10);
    cycle(1'b0, 1'b0, 1'b1, 32'h208, 0);
    check("t2_dropped", BW_CHK'(o_valid), BW_CHK'(1'b0));
    check("t2_req_addr", BW_CHK'(o_mem_addr), BW_CHK'(32'h200));
    run_until_valid(1'b1, 0, 10);
    check("t2_pc", BW_CHK'(o_pc), BW_CHK'(32'h208));
    check("t2_sel", BW_CHK'(o_pc_mod_select), BW_CHK'(2'd2));
    check("t2_ub", BW_CHK'(o_pc_upperbound), BW_CHK'(2'd3));
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check("t2_next_addr", BW_CHK'(o_mem_addr), BW_CHK'(32'h210));

    // Flush while waiting; the stale response arrives later.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 3);
    cycle(1'b0, 1'b0, 1'b1, 32'h204, 0);
    check("t3_drain_mem_valid", BW_CHK'(o_mem_valid), BW_CHK'(1'b0));
    run_until_mem_valid(10);
    check("t3_req_addr", BW_CHK'(o_mem_addr), BW_CHK'(32'h200));
    check("t3_pc", BW_CHK'(o_pc), BW_CHK'(32'h204));

    // Back-pressure from the FIFO.
    run_until_valid(1'b1, 0, 10);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0, 0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check("t4_after_xfer_valid", BW_CHK'(o_valid), BW_CHK'(1'b0));

    // Memory stalls in REQ with a flush part-way through.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);
    cycle(1'b0, 1'b0, 1'b1, 32'h300, 0);
    check("t5_held_addr", BW_CHK'(o_mem_addr), BW_CHK'(32'h300));
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 0);
    check("t5_accepted", BW_CHK'(o_mem_valid), BW_CHK'(1'b0));
    run_until_valid(1'b1, 0, 10);
    check("t5_pc", BW_CHK'(o_pc), BW_CHK'(32'h300));
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);

    // Block with a branch in slot 1.
    cycle(1'b0, 1'b0, 1'b1, 32'h400, 0);
    run_until_valid(1'b1, 1, 10);
    check("t6_ub", BW_CHK'(o_pc_upperbound), BW_CHK'(STOP_EN ? 2'd1 : 2'd3));
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check("t6_next_addr", BW_CHK'(o_mem_addr), BW_CHK'(STOP_EN ? 32'h400 : 32'h410));
    check("t6_next_pc", BW_CHK'(o_pc), BW_CHK'(STOP_EN ? 32'h408 : 32'h410));
    run_until_valid(1'b1, 0, 10);
    check("t6_next_sel", BW_CHK'(o_pc_mod_select), BW_CHK'(STOP_EN ? 2'd2 : 2'd0));
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);

    // Random traffic, including redirects near the top of the address space.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      fpc = $urandom & 32'h0000_003C;
      fpc = fpc | (($urandom_range(0, 1) == 0) ? 32'hFFFF_FFC0 : 32'h0000_1000);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, fpc, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
